// File: rtl/key_lock_pkg.sv
// key_lock_pkg
// Shared definitions for the key-locked core controller, its test harness
// and the locked-core wrappers.
//   key_state_e        : controller state encoding (2 bits)
//   KEY_W_DEF          : default candidate key width
//   MAX_FAIL_DEF       : default failed attempts before lockout
//   TIMEOUT_STEPS_DEF  : default step pulses allowed in RUN without a verdict
package key_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } key_state_e;

    localparam int KEY_W_DEF         = 8;
    localparam int MAX_FAIL_DEF      = 5;
    localparam int TIMEOUT_STEPS_DEF = 16;

endpackage

// File: rtl/key_bit_mux.sv
// key_bit_mux
// Holds the candidate key and a wrapping bit index; presents the selected
// key bit to the locked core.
//   clk, rst        : clock, asynchronous active-high reset
//   load_i          : capture key_data_i and clear the index to 0
//   key_data_i      : candidate key
//   adv_i           : advance the index by one, wrapping KEY_W-1 -> 0
//   key_bit_o       : key_q[idx_q]
//   key_idx_o       : current bit index
module key_bit_mux #(
    parameter int KEY_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [KEY_W-1:0] key_data_i,
    input  logic             adv_i,
    output logic             key_bit_o,
    output logic [IDX_W-1:0] key_idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_W - 1);

    logic [KEY_W-1:0] key_q, key_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // load wins over adv; the controller never asserts both together.
    always_comb begin
        key_d = key_q;
        idx_d = idx_q;
        if (load_i) begin
            key_d = key_data_i;
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            idx_q <= '0;
        end else begin
            key_q <= key_d;
            idx_q <= idx_d;
        end
    end

    assign key_bit_o = key_q[idx_q];
    assign key_idx_o = idx_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Sequences a candidate key, one bit per key-dependent transition, into the
// single keyinput0 port of a locked FSM; counts failed attempts and locks out.
// Handshake: a key transfers on the rising edge where key_valid && key_ready;
// key_ready is high only in IDLE and never depends on key_valid.
//   clk, rst              : clock, asynchronous active-high reset
//   key_valid/key_data    : candidate key offer
//   key_ready             : high in IDLE
//   step                  : pulse per key-dependent transition of the core
//   check_valid/check_pass: checker verdict pulse
//   keyinput0, key_idx    : key bit driven to the core and its index
//   busy/unlocked/lockout : RUN / UNLOCKED / LOCKOUT state flags
//   fail_count            : failed attempts (saturating at MAX_FAIL)
//   dbg_state             : raw FSM state for observation
module key_schedule_ctrl
    import key_lock_pkg::*;
#(
    parameter int KEY_W         = KEY_W_DEF,
    parameter int IDX_W         = $clog2(KEY_W),
    parameter int MAX_FAIL      = MAX_FAIL_DEF,
    parameter int FAIL_W        = $clog2(MAX_FAIL + 1),
    parameter int TIMEOUT_STEPS = TIMEOUT_STEPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_data,
    output logic              key_ready,
    input  logic              step,
    input  logic              check_valid,
    input  logic              check_pass,
    output logic              keyinput0,
    output logic [IDX_W-1:0]  key_idx,
    output logic              busy,
    output logic              unlocked,
    output logic              lockout,
    output logic [FAIL_W-1:0] fail_count,
    output key_state_e        dbg_state
);

    localparam int SC_W = $clog2(TIMEOUT_STEPS + 1);
    localparam logic [SC_W-1:0]   TIMEOUT_C  = SC_W'(TIMEOUT_STEPS);
    localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);

    key_state_e        state_q, state_d;
    logic [SC_W-1:0]   step_cnt_q, step_cnt_d;
    logic [FAIL_W-1:0] fail_count_q, fail_count_d;
    logic              load, adv, fail, key_bit;

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        fail_count_d = fail_count_q;
        load         = 1'b0;
        adv          = 1'b0;
        fail         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    load       = 1'b1;
                    step_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // A step on the same cycle as a verdict still advances the index.
                adv = step;
                if (step) begin
                    step_cnt_d = step_cnt_q + SC_W'(1);
                end
                // A verdict outranks a timeout landing on the same step.
                if (check_valid) begin
                    if (check_pass) begin
                        fail_count_d = '0;
                        state_d      = ST_UNLOCKED;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (step && (step_cnt_q + SC_W'(1) == TIMEOUT_C)) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    fail_count_d = (fail_count_q == MAX_FAIL_C) ? fail_count_q
                                                                : fail_count_q + FAIL_W'(1);
                    state_d      = (fail_count_q + FAIL_W'(1) == MAX_FAIL_C) ? ST_LOCKOUT
                                                                            : ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                adv = step;
            end
            default: begin
                // LOCKOUT: everything frozen until reset.
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            fail_count_q <= fail_count_d;
        end
    end

    key_bit_mux #(
        .KEY_W (KEY_W),
        .IDX_W (IDX_W)
    ) u_key_bit_mux (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .key_data_i (key_data),
        .adv_i      (adv),
        .key_bit_o  (key_bit),
        .key_idx_o  (key_idx)
    );

    assign key_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign unlocked   = (state_q == ST_UNLOCKED);
    assign lockout    = (state_q == ST_LOCKOUT);
    // The key bit only reaches the core while a key is being applied or is live.
    assign keyinput0  = key_bit && (state_q == ST_RUN || state_q == ST_UNLOCKED);
    assign fail_count = fail_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;
    import key_lock_pkg::*;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       step;
    logic       check_valid;
    logic       check_pass;
    logic       keyinput0;
    logic [2:0] key_idx;
    logic       busy;
    logic       unlocked;
    logic       lockout;
    logic [2:0] fail_count;
    key_state_e dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    key_schedule_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .key_ready   (key_ready),
        .step        (step),
        .check_valid (check_valid),
        .check_pass  (check_pass),
        .keyinput0   (keyinput0),
        .key_idx     (key_idx),
        .busy        (busy),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .fail_count  (fail_count),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {key_ready, keyinput0, key_idx[2:0], busy, unlocked, lockout, fail_count[2:0]}
    typedef struct {
        string      name;
        logic       rst;
        logic       kv;
        logic [7:0] kd;
        logic       st;
        logic       cv;
        logic       cp;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] ex(input logic rdy, input logic k, input logic [2:0] idx,
                                       input logic bsy, input logic unl, input logic lo,
                                       input logic [2:0] fc);
        return {rdy, k, idx, bsy, unl, lo, fc};
    endfunction

    task automatic push(input string n, input logic r, input logic kv, input logic [7:0] kd,
                        input logic st, input logic cv, input logic cp, input logic [10:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.kv = kv; v.kd = kd;
        v.st = st; v.cv = cv; v.cp = cp; v.exp = e;
        vecs.push_back(v);
    endtask

    localparam logic [10:0] RST_EXP = 11'b1_0_000_0_0_0_000;

    // Load key k, then apply n steps in RUN (no verdict); expected index wraps mod 8.
    task automatic load_and_step(input string n, input logic [7:0] k, input int steps,
                                 input logic [2:0] fc);
        logic [2:0] idx;
        idx = 3'd0;
        push({n, "_load"}, 0, 1, k, 0, 0, 0, ex(0, k[idx], idx, 1, 0, 0, fc));
        for (int j = 0; j < steps; j++) begin
            idx = idx + 3'd1;
            push({n, "_step"}, 0, 0, 8'h00, 1, 0, 0, ex(0, k[idx], idx, 1, 0, 0, fc));
        end
    endtask

    // Driver: one row per clock; inputs set 1ns after the edge, outputs checked 1ns after the next.
    task automatic apply(input vec_t v, input int i);
        logic [10:0] got;
        rst         = v.rst;
        key_valid   = v.kv;
        key_data    = v.kd;
        step        = v.st;
        check_valid = v.cv;
        check_pass  = v.cp;
        @(posedge clk);
        #1;
        got = {key_ready, keyinput0, key_idx, busy, unlocked, lockout, fail_count};
        n_cmp++;
        if (got !== v.exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got rdy/k/idx/busy/unl/lo/fc=%b/%b/%0d/%b/%b/%b/%0d exp=%b/%b/%0d/%b/%b/%b/%0d",
                     i, v.name, got[10], got[9], got[8:6], got[5], got[4], got[3], got[2:0],
                     v.exp[10], v.exp[9], v.exp[8:6], v.exp[5], v.exp[4], v.exp[3], v.exp[2:0]);
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_data = '0;
        step = 1'b0; check_valid = 1'b0; check_pass = 1'b0;

        // Reset and A5 with three steps: keyinput0 1,0,1,0
        push("reset", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        push("idle_ready", 0, 0, 8'h00, 0, 0, 0, RST_EXP);
        push("a5_load", 0, 1, 8'hA5, 0, 0, 0, ex(0, 1, 3'd0, 1, 0, 0, 3'd0));
        push("a5_s1", 0, 0, 8'h00, 1, 0, 0, ex(0, 0, 3'd1, 1, 0, 0, 3'd0));
        push("a5_s2", 0, 0, 8'h00, 1, 0, 0, ex(0, 1, 3'd2, 1, 0, 0, 3'd0));
        push("a5_s3", 0, 0, 8'h00, 1, 0, 0, ex(0, 0, 3'd3, 1, 0, 0, 3'd0));
        push("a5_runkey_ignored", 0, 1, 8'hFF, 0, 0, 0, ex(0, 0, 3'd3, 1, 0, 0, 3'd0));

        // 81 with nine steps (wrap to 1), then pass -> UNLOCKED
        push("rst2", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        load_and_step("k81", 8'h81, 9, 3'd0);
        push("k81_pass", 0, 0, 8'h00, 0, 1, 1, ex(0, 0, 3'd1, 0, 1, 0, 3'd0));
        push("unl_key_ignored", 0, 1, 8'hFF, 0, 0, 0, ex(0, 0, 3'd1, 0, 1, 0, 3'd0));
        push("unl_check_ignored", 0, 0, 8'h00, 0, 1, 0, ex(0, 0, 3'd1, 0, 1, 0, 3'd0));
        push("unl_step_wrap", 0, 0, 8'h00, 1, 0, 0, ex(0, 0, 3'd2, 0, 1, 0, 3'd0));

        // Timeout: 16 steps with no verdict -> IDLE, fail_count=1
        push("rst3", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        load_and_step("to", 8'hC3, 15, 3'd0);
        push("to_16th", 0, 0, 8'h00, 1, 0, 0, ex(1, 0, 3'd0, 0, 0, 0, 3'd1));
        // Verdict beats timeout on the 16th step
        load_and_step("tp", 8'h01, 15, 3'd1);
        push("tp_pass_on_16th", 0, 0, 8'h00, 1, 1, 1, ex(0, 1, 3'd0, 0, 1, 0, 3'd0));

        // step + fail together at idx 7 -> idx 0, IDLE, fail_count+1
        push("rst4", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        load_and_step("sf", 8'h80, 7, 3'd0);
        push("sf_step_fail", 0, 0, 8'h00, 1, 1, 0, ex(1, 0, 3'd0, 0, 0, 0, 3'd1));

        // Mid-RUN reset at idx 4, fail_count 2
        push("mr_load1", 0, 1, 8'h10, 0, 0, 0, ex(0, 0, 3'd0, 1, 0, 0, 3'd1));
        push("mr_fail1", 0, 0, 8'h00, 0, 1, 0, ex(1, 0, 3'd0, 0, 0, 0, 3'd2));
        load_and_step("mr", 8'h10, 4, 3'd2);
        push("mr_reset", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        push("mr_after", 0, 0, 8'h00, 0, 0, 0, RST_EXP);

        // Five failed attempts -> LOCKOUT
        for (int a = 1; a <= 5; a++) begin
            push("lo_load", 0, 1, 8'hA5, 0, 0, 0, ex(0, 1, 3'd0, 1, 0, 0, 3'(a - 1)));
            if (a < 5)
                push("lo_fail", 0, 0, 8'h00, 0, 1, 0, ex(1, 0, 3'd0, 0, 0, 0, 3'(a)));
            else
                push("lo_fail5", 0, 0, 8'h00, 0, 1, 0, ex(0, 0, 3'd0, 0, 0, 1, 3'd5));
        end
        push("lo_key_ignored", 0, 1, 8'hFF, 0, 0, 0, ex(0, 0, 3'd0, 0, 0, 1, 3'd5));
        push("lo_step_frozen", 0, 0, 8'h00, 1, 0, 0, ex(0, 0, 3'd0, 0, 0, 1, 3'd5));
        push("lo_pass_ignored", 0, 0, 8'h00, 1, 1, 1, ex(0, 0, 3'd0, 0, 0, 1, 3'd5));
        push("lo_rst", 1, 0, 8'h00, 0, 0, 0, RST_EXP);
        push("lo_rst_after", 0, 0, 8'h00, 0, 0, 0, RST_EXP);

        // Walk the table
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Hand-written: async reset takes effect without a clock edge
        rst = 1'b0; key_valid = 1'b1; key_data = 8'hFF;
        step = 1'b0; check_valid = 1'b0; check_pass = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        n_cmp++;
        if (!(busy === 1'b1 && keyinput0 === 1'b1)) begin
            n_fail++;
            $display("FAIL async_pre: busy=%b keyinput0=%b exp busy=1 keyinput0=1", busy, keyinput0);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({key_ready, keyinput0, busy, key_idx, fail_count} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL async_rst: rdy=%b k=%b busy=%b idx=%0d fc=%0d exp rdy=1 k=0 busy=0 idx=0 fc=0",
                     key_ready, keyinput0, busy, key_idx, fail_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
